egg_timer_ctrl: RTL and testbench
=================================

Name: egg_timer_ctrl

Overview:
- Sequencing controller for the egg timer.
- Turns four button inputs into a set/run/pause/alarm state machine and owns the seconds counter.
- Drives the 12-bit `count` (total seconds, 0..3599) consumed by bcd_to_time → bcd_to_7seg.
- Also produces alarm and display-blank controls and generates its own 1 Hz tick from the system clock.

Parameters:
- TICK_DIV, 125000000, clk cycles per timer second. Must be ≥2; benches use 4.
- ALARM_SECS, 10, seconds the alarm stays asserted in DONE before auto-return to SET. Must be ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  start/pause toggle, level input, already debounced and synchronous
- btn_min  in  1  add one minute (SET only), level
- btn_sec  in  1  add one second (SET only), level
- btn_clear  in  1  clear/abort, level
- count  out  12  remaining seconds = min_r*60 + sec_r; combinational from registers, no extra latency
- running  out  1  1 in RUN
- alarm  out  1  1 in DONE
- blank  out  1  display blank request, blinks in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=SET; min_r=sec_r=0; count=0; running=alarm=blank=0.
  - Prescaler, alarm-second counter and button history registers = 0.
  - Takes effect immediately, including mid-RUN.
- Button press:
  - press = level & ~prev, where prev is registered level.
  - One press per rising edge; a held button is never repeated.
  - Priority on same cycle: clear > start > min/sec.
- Prescaler tick_cnt runs 0..TICK_DIV-1:
  - Counts in RUN and DONE; holds in PAUSE.
  - Cleared on SET→RUN and on RUN→DONE.
  - sec_tick = (tick_cnt==TICK_DIV-1) in the counting state.
- States: SET, RUN, PAUSE, DONE. `running` and `alarm` are decoded from registered state.
- SET:
  - min press: min_r = (min_r==59) ? 0 : min_r+1; sec_r unchanged.
  - sec press: sec_r = (sec_r==59) ? 0 : sec_r+1; no carry into min_r.
  - Simultaneous min+sec presses: both applied.
  - clear: min_r=sec_r=0.
  - start with count≠0 → RUN. start with count==0 is ignored.
- RUN:
  - On sec_tick, decrement with borrow: sec_r==0 → sec_r=59, min_r-1; else sec_r-1.
  - When the decrement takes count 1→0, go to DONE on the same edge.
  - start → PAUSE, with tick_cnt retained.
  - clear → SET with min_r=sec_r=0.
  - min/sec presses are ignored.
- PAUSE:
  - count frozen.
  - start → RUN; the prescaler resumes from its held value.
  - clear → SET, zeroed.
  - min/sec ignored.
- DONE:
  - count=0, alarm=1.
  - blank = (tick_cnt ≥ TICK_DIV/2).
  - Alarm-second counter increments on each sec_tick. After ALARM_SECS ticks → SET with alarm=blank=0.
  - Any button press → SET on the next edge; the counter is cleared.
- Width rules:
  - count never exceeds 3599.
  - min_r and sec_r are 6 bits each, always 0..59.
  - Multiplication by 60 is done as (min_r<<6)-(min_r<<2).
- blank=0 in every state except DONE.

Decomposition:
- Package egg_timer_pkg:
  - state enum {SET, RUN, PAUSE, DONE}
  - SECS_PER_MIN=60, MAX_MIN=59, MAX_COUNT=3599, COUNT_W=12
- Sub-module btn_edge: rising-edge pulse with async active-low reset. Instanced once per button.

Test Plan (TICK_DIV=4, ALARM_SECS=3):
1. Reset, then press start with count 0 → state stays SET, running=0, count=0.
2. btn_min ×2, btn_sec ×3 → count=123.
   - start → running=1.
   - count=122 four clocks after RUN entry.
   - count reaches 0 after 123×4 clocks, alarm=1 on that edge.
3. Set count=60, start → after 4 clocks count=59 (min_r=0, sec_r=59, borrow).
4. Wrap:
   - 60 btn_min presses → count=0.
   - 61 btn_sec presses → count=1.
   - Holding btn_min high for 10 clocks counts as 1 press.
5. Pause: run from 100.
   - start at tick_cnt=2 → PAUSE; hold 20 clocks, count unchanged.
   - start → next decrement 2 clocks after resume.
   - clear in PAUSE → SET, count=0.
6. DONE: alarm=1 for 12 clocks, blank toggles every 2 clocks, then SET with count=0 and alarm=0.
   - Repeat the run and press btn_sec in DONE → alarm=0 next edge, count stays 0.
   - Drop rst_n mid-RUN between clock edges → running=0 and count=0 immediately.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer controller.
// Time is held as minutes/seconds and flattened to total seconds for display.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int               SECS_PER_MIN = 60;
  localparam logic [5:0]       MAX_MIN      = 6'(SECS_PER_MIN - 1);
  localparam int               COUNT_W      = 12;
  localparam logic [COUNT_W-1:0] MAX_COUNT  = 12'd3599;

  // min*60 as min*64 - min*4, avoiding a multiplier.
  function automatic logic [COUNT_W-1:0] mmss_to_count(input logic [5:0] min_v,
                                                       input logic [5:0] sec_v);
    return {min_v, 6'b0} - {4'b0, min_v, 2'b0} + {6'b0, sec_v};
  endfunction

endpackage

// File: rtl/egg_timer_ctrl_btn_edge.sv
// Rising-edge detector: one-cycle press pulse per low-to-high transition of a
// debounced, synchronous button level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= btn_i;
  end

  assign press_o = btn_i & ~prev_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: set/run/pause/alarm FSM, seconds counter and 1 Hz
// prescaler. count/running/alarm/blank are decoded directly from registers.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV   = 125000000,
  parameter int ALARM_SECS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_min,
  input  logic               btn_sec,
  input  logic               btn_clear,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               alarm,
  output logic               blank
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int ALARM_W = $clog2(ALARM_SECS + 1);

  localparam int B_SEC   = 0;
  localparam int B_MIN   = 1;
  localparam int B_START = 2;
  localparam int B_CLEAR = 3;

  logic [3:0] btn_lvl;
  logic [3:0] btn_press;

  assign btn_lvl = {btn_clear, btn_start, btn_min, btn_sec};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_lvl[gi]),
      .press_o(btn_press[gi])
    );
  end

  state_e              state_q, state_d;
  logic [5:0]          min_q, min_d;
  logic [5:0]          sec_q, sec_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ALARM_W-1:0]  alarm_cnt_q, alarm_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SET;
      min_q       <= '0;
      sec_q       <= '0;
      tick_q      <= '0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  logic count_nz;
  logic sec_tick;

  assign count_nz = (min_q != 6'd0) || (sec_q != 6'd0);
  assign sec_tick = ((state_q == RUN) || (state_q == DONE)) &&
                    (tick_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tick_d      = tick_q;
    alarm_cnt_d = alarm_cnt_q;

    unique case (state_q)
      SET: begin
        tick_d      = '0;
        alarm_cnt_d = '0;
        if (btn_press[B_CLEAR]) begin
          min_d = '0;
          sec_d = '0;
        end else if (btn_press[B_START] && count_nz) begin
          state_d = RUN;
        end else begin
          // A start with nothing loaded is a no-op, so min/sec still apply.
          if (btn_press[B_MIN]) min_d = (min_q == MAX_MIN) ? 6'd0 : min_q + 6'd1;
          if (btn_press[B_SEC]) sec_d = (sec_q == MAX_MIN) ? 6'd0 : sec_q + 6'd1;
        end
      end

      RUN: begin
        if (btn_press[B_CLEAR]) begin
          state_d = SET;
          min_d   = '0;
          sec_d   = '0;
          tick_d  = '0;
        end else if (btn_press[B_START]) begin
          // Pause wins over a coincident tick; the prescaler phase is kept.
          state_d = PAUSE;
        end else if (sec_tick) begin
          tick_d = '0;
          if (sec_q == 6'd0) begin
            sec_d = MAX_MIN;
            min_d = min_q - 6'd1;
          end else begin
            sec_d = sec_q - 6'd1;
          end
          if ((min_q == 6'd0) && (sec_q == 6'd1)) state_d = DONE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      PAUSE: begin
        if (btn_press[B_CLEAR]) begin
          state_d = SET;
          min_d   = '0;
          sec_d   = '0;
          tick_d  = '0;
        end else if (btn_press[B_START]) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (btn_press != 4'b0000) begin
          state_d     = SET;
          alarm_cnt_d = '0;
          tick_d      = '0;
        end else if (sec_tick) begin
          tick_d = '0;
          if (alarm_cnt_q == ALARM_W'(ALARM_SECS - 1)) begin
            state_d     = SET;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
    endcase
  end

  assign count   = mmss_to_count(min_q, sec_q);
  assign running = (state_q == RUN);
  assign alarm   = (state_q == DONE);
  assign blank   = (state_q == DONE) && (tick_q >= TICK_W'(TICK_DIV / 2));

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: directed scenarios plus random button
// traffic, all compared every cycle against a total-seconds behavioural model.
module tb_egg_timer_ctrl;
  import egg_timer_pkg::*;

  localparam int TD = 4;
  localparam int AS = 3;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_SEC   = 4'b0001;
  localparam logic [3:0] B_MIN   = 4'b0010;
  localparam logic [3:0] B_START = 4'b0100;
  localparam logic [3:0] B_CLR   = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_min = 1'b0;
  logic        btn_sec = 1'b0;
  logic        btn_clear = 1'b0;
  logic [11:0] count;
  logic        running;
  logic        alarm;
  logic        blank;

  egg_timer_ctrl #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_start(btn_start),
    .btn_min  (btn_min),
    .btn_sec  (btn_sec),
    .btn_clear(btn_clear),
    .count    (count),
    .running  (running),
    .alarm    (alarm),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining time as plain seconds, time-within-second as a phase.
  typedef enum int {M_SET, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t  m_state;
  int       m_secs;
  int       m_phase;
  int       m_alarm_secs;
  bit [3:0] m_prev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state      = M_SET;
    m_secs       = 0;
    m_phase      = 0;
    m_alarm_secs = 0;
    m_prev       = 4'b0000;
  endtask

  task automatic model_step(input bit [3:0] lvl);
    bit [3:0] p;
    int mm, ss;
    p      = lvl & ~m_prev;
    m_prev = lvl;
    case (m_state)
      M_SET: begin
        if (p[3]) m_secs = 0;
        else if (p[2] && m_secs != 0) begin
          m_state = M_RUN;
          m_phase = 0;
        end else begin
          mm = m_secs / 60;
          ss = m_secs % 60;
          if (p[1]) mm = (mm + 1) % 60;
          if (p[0]) ss = (ss + 1) % 60;
          m_secs = mm * 60 + ss;
        end
      end
      M_RUN: begin
        if (p[3]) begin
          m_state = M_SET;
          m_secs  = 0;
        end else if (p[2]) m_state = M_PAUSE;
        else if (m_phase == TD - 1) begin
          m_phase = 0;
          m_secs  = m_secs - 1;
          if (m_secs == 0) begin
            m_state      = M_DONE;
            m_alarm_secs = 0;
          end
        end else m_phase++;
      end
      M_PAUSE: begin
        if (p[3]) begin
          m_state = M_SET;
          m_secs  = 0;
        end else if (p[2]) m_state = M_RUN;
      end
      default: begin
        if (p != 4'b0000) m_state = M_SET;
        else if (m_phase == TD - 1) begin
          m_phase = 0;
          m_alarm_secs++;
          if (m_alarm_secs == AS) m_state = M_SET;
        end else m_phase++;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("count",   int'(count),   m_secs);
    chk("running", int'(running), int'(m_state == M_RUN));
    chk("alarm",   int'(alarm),   int'(m_state == M_DONE));
    chk("blank",   int'(blank),   int'(m_state == M_DONE && m_phase >= TD / 2));
    chk("count_range", int'(count <= MAX_COUNT), 1);
  endtask

  // Drive levels at the falling edge, clock once, compare at the next falling edge.
  task automatic cyc(input bit [3:0] lvl);
    btn_sec   = lvl[0];
    btn_min   = lvl[1];
    btn_start = lvl[2];
    btn_clear = lvl[3];
    model_step(lvl);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input bit [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(b);
      cyc(B_NONE);
    end
  endtask

  task automatic run_to_alarm(input int budget);
    int k;
    k = 0;
    while (!alarm && k < budget) begin
      cyc(B_NONE);
      k++;
    end
    chk("alarm_within_budget", int'(alarm), 1);
  endtask

  initial begin
    int n_alarm;
    bit [3:0] lvl;
    int pr[4];

    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    chk("reset_count", int'(count), 0);

    // Start with nothing loaded is ignored.
    cyc(B_START);
    chk("start_zero_running", int'(running), 0);
    chk("start_zero_count", int'(count), 0);
    cyc(B_NONE);

    // 2 min + 3 sec, full countdown, then the alarm window.
    press(B_MIN, 2);
    press(B_SEC, 3);
    chk("set_123", int'(count), 123);
    cyc(B_START);
    chk("run_entry", int'(running), 1);
    repeat (4) cyc(B_NONE);
    chk("first_dec_122", int'(count), 122);
    repeat (123 * 4 - 5) cyc(B_NONE);
    chk("before_end_count", int'(count), 1);
    chk("before_end_alarm", int'(alarm), 0);
    cyc(B_NONE);
    chk("end_count", int'(count), 0);
    chk("end_alarm", int'(alarm), 1);
    n_alarm = 1;
    for (int k = 0; k < 40 && alarm; k++) begin
      cyc(B_NONE);
      if (alarm) n_alarm++;
      if (k == 1) chk("blank_third_cycle", int'(blank), 1);
    end
    chk("alarm_len", n_alarm, 12);
    chk("after_alarm_count", int'(count), 0);

    // Borrow from minutes.
    press(B_MIN, 1);
    chk("set_60", int'(count), 60);
    cyc(B_START);
    repeat (4) cyc(B_NONE);
    chk("borrow_59", int'(count), 59);
    press(B_CLR, 1);

    // Wrapping and held-button behaviour.
    press(B_MIN, 60);
    chk("min_wrap", int'(count), 0);
    press(B_SEC, 61);
    chk("sec_wrap", int'(count), 1);
    repeat (10) cyc(B_MIN);
    cyc(B_NONE);
    chk("held_min", int'(count), 61);
    press(B_CLR, 1);

    // Pause mid-second, resume from the held phase, clear from PAUSE.
    press(B_MIN, 1);
    press(B_SEC, 40);
    chk("set_100", int'(count), 100);
    cyc(B_START);
    cyc(B_NONE);
    cyc(B_NONE);
    cyc(B_START);
    chk("paused", int'(running), 0);
    repeat (20) cyc(B_NONE);
    chk("pause_hold", int'(count), 100);
    cyc(B_START);
    chk("resumed", int'(running), 1);
    cyc(B_NONE);
    chk("resume_no_dec", int'(count), 100);
    cyc(B_NONE);
    chk("resume_dec", int'(count), 99);
    cyc(B_START);
    cyc(B_CLR);
    chk("pause_clear", int'(count), 0);
    cyc(B_NONE);

    // Button press cancels the alarm.
    press(B_SEC, 2);
    cyc(B_START);
    run_to_alarm(100);
    cyc(B_SEC);
    chk("alarm_cancel", int'(alarm), 0);
    chk("alarm_cancel_count", int'(count), 0);
    cyc(B_NONE);

    // Asynchronous reset between clock edges.
    press(B_MIN, 1);
    cyc(B_START);
    repeat (5) cyc(B_NONE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_count", int'(count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Random button traffic.
    lvl = 4'b0000;
    for (int i = 0; i < 5000; i++) begin
      pr[0] = (m_state == M_SET) ? 20 : 2;
      pr[1] = (m_state == M_SET) ? 20 : 2;
      pr[2] = (m_state == M_RUN) ? 1 : 6;
      pr[3] = 1;
      for (int b = 0; b < 4; b++) begin
        if (lvl[b]) lvl[b] = ($urandom_range(0, 99) < 50);
        else        lvl[b] = ($urandom_range(0, 99) < pr[b]);
      end
      cyc(lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
